// File: rtl/regfile_write_queue_pkg.sv
// Shared types for the register-file write-back queue: entry layout and rd decode.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction
endpackage

// File: rtl/regfile_write_queue_if.sv
// Producer/consumer bundle for the write queue: two result inputs, write port, hazard mask.
interface regfile_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_add;
  logic [DATA_W-1:0] write_data;
  logic [(1<<ADDR_W)-1:0] pend_mask;
  logic [CNT_W-1:0]  count;

  modport master (
    output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
    input  ld_ready, alu_ready, RegWrite, write_add, write_data, pend_mask, count
  );

  modport slave (
    input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
    output ld_ready, alu_ready, RegWrite, write_add, write_data, pend_mask, count
  );
endinterface

// File: rtl/regfile_write_queue_wb_fifo.sv
// In-order entry FIFO with two ordered push ports (push0 older) and an always-on pop.
module wb_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push0,
  input  wb_entry_t             push0_ent,
  input  logic                  push1,
  input  wb_entry_t             push1_ent,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count,
  output logic [DEPTH-1:0]      ent_vld,
  output wb_entry_t [DEPTH-1:0] ents
);
  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr1;
  logic             w_pop;

  assign w_pop = (r_count != '0);
  assign w_wr1 = r_wr_ptr + PTR_W'(push0);

  // Storage is deliberately left out of reset; validity comes from count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push0) r_mem[r_wr_ptr] <= push0_ent;
    if (push1) r_mem[w_wr1]    <= push1_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(w_pop);
    end
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      logic [PTR_W-1:0] w_off;
      assign w_off      = PTR_W'(i) - r_rd_ptr;
      assign ent_vld[i] = (CNT_W'(w_off) < r_count);
      assign ents[i]    = r_mem[i];
    end
  endgenerate

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
endmodule

// File: rtl/regfile_write_queue.sv
// Write-back queue: accepts load/ALU results, retires one per cycle into the register file.
module regfile_write_queue
  import mips_pkg::wb_entry_t, mips_pkg::REG_ZERO, mips_pkg::rd_onehot;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_queue_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 1 << ADDR_W;

  wb_entry_t             w_ld_ent, w_alu_ent, w_head;
  wb_entry_t [DEPTH-1:0] w_ents;
  logic [DEPTH-1:0]      w_ent_vld;
  logic [CNT_W-1:0]      w_count;
  logic                  w_ld_acc, w_alu_acc, w_push0, w_push1;
  logic [DEPTH-1:0][NREG-1:0] w_ent_mask;
  logic [NREG-1:0]       w_pend;

  // Readiness uses registered count only: the pop in this cycle does not open space.
  assign bus.ld_ready  = rst && (w_count < CNT_W'(DEPTH));
  assign bus.alu_ready = rst && ((w_count + CNT_W'(bus.ld_valid)) < CNT_W'(DEPTH));

  assign w_ld_acc  = bus.ld_valid  && bus.ld_ready;
  assign w_alu_acc = bus.alu_valid && bus.alu_ready;
  // r0 writes complete the handshake but are never queued.
  assign w_push0   = w_ld_acc  && (bus.ld_rd  != REG_ZERO);
  assign w_push1   = w_alu_acc && (bus.alu_rd != REG_ZERO);

  assign w_ld_ent  = '{rd: bus.ld_rd,  data: bus.ld_data};
  assign w_alu_ent = '{rd: bus.alu_rd, data: bus.alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push0     (w_push0),
    .push0_ent (w_ld_ent),
    .push1     (w_push1),
    .push1_ent (w_alu_ent),
    .head      (w_head),
    .count     (w_count),
    .ent_vld   (w_ent_vld),
    .ents      (w_ents)
  );

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_mask
      assign w_ent_mask[i] = w_ent_vld[i] ? rd_onehot(w_ents[i].rd) : '0;
    end
  endgenerate

  always_comb begin
    w_pend = '0;
    for (int k = 0; k < DEPTH; k++) w_pend = w_pend | w_ent_mask[k];
  end

  assign bus.pend_mask  = w_pend;
  assign bus.RegWrite   = (w_count != '0);
  assign bus.write_add  = w_head.rd;
  assign bus.write_data = w_head.data;
  assign bus.count      = w_count;
endmodule
